// File: rtl/mem_refill_arbiter.sv
// Round-robin refill arbiter: shares one L2 acquire/grant port between N_REQ
// refill clients, one block acquire in flight, grant burst steered to the owner.
module mem_refill_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned PADDR_W = 26,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned BEAT_W  = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*PADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ-1:0]         req_kill_i,
  output logic                     mem_acquire_valid_o,
  output logic [PADDR_W-1:0]       mem_acquire_addr_o,
  input  logic                     mem_acquire_ready_i,
  input  logic                     mem_grant_valid_i,
  input  logic [DATA_W-1:0]        mem_grant_data_i,
  input  logic [BEAT_W-1:0]        mem_grant_beat_i,
  output logic                     mem_grant_ready_o,
  output logic [N_REQ-1:0]         resp_valid_o,
  output logic [DATA_W-1:0]        resp_data_o,
  output logic [BEAT_W-1:0]        resp_beat_o,
  output logic                     resp_last_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CND_W = OWN_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_GRANT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               killed_q, killed_d;

  logic               pick_found_c;
  logic [OWN_W-1:0]   pick_idx_c;
  logic [CND_W-1:0]   cand_c;
  logic [OWN_W-1:0]   next_ptr_c;
  logic               owner_kill_c;
  logic               last_beat_c;

  assign mem_grant_ready_o  = 1'b1;
  assign busy_o             = (state_q != S_IDLE);
  assign mem_acquire_addr_o = (state_q == S_ACQ) ? addr_q : '0;
  assign owner_kill_c       = req_kill_i[owner_q];
  assign last_beat_c        = &mem_grant_beat_i;
  assign next_ptr_c         = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);

  // Round-robin pick: first valid client scanning upward from rr_ptr, wrapping.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_c = CND_W'(rr_ptr_q) + CND_W'(i);
      if (cand_c >= CND_W'(N_REQ)) cand_c = cand_c - CND_W'(N_REQ);
      if (!pick_found_c && req_valid_i[cand_c[OWN_W-1:0]]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c[OWN_W-1:0];
      end
    end
  end

  // Next-state and output decode; grant data path is a zero-latency forward.
  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    owner_d             = owner_q;
    addr_d              = addr_q;
    tmo_cnt_d           = tmo_cnt_q;
    killed_d            = killed_q;
    req_ready_o         = '0;
    mem_acquire_valid_o = 1'b0;
    resp_valid_o        = '0;
    resp_data_o         = '0;
    resp_beat_o         = '0;
    resp_last_o         = 1'b0;
    timeout_o           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          req_ready_o[pick_idx_c] = 1'b1;
          owner_d  = pick_idx_c;
          addr_d   = req_addr_i[pick_idx_c*PADDR_W +: PADDR_W];
          killed_d = 1'b0;
          state_d  = S_ACQ;
        end
      end
      S_ACQ: begin
        mem_acquire_valid_o = 1'b1;
        // A kill here still lets the acquire complete; its burst is drained silently.
        if (owner_kill_c) killed_d = 1'b1;
        if (mem_acquire_ready_i) begin
          state_d   = S_GRANT;
          tmo_cnt_d = '0;
        end
      end
      S_GRANT: begin
        resp_data_o = mem_grant_data_i;
        resp_beat_o = mem_grant_beat_i;
        if (owner_kill_c) killed_d = 1'b1;
        if (mem_grant_valid_i) begin
          resp_valid_o[owner_q] = !killed_q && !owner_kill_c;
          resp_last_o = last_beat_c;
          tmo_cnt_d   = '0;
          if (last_beat_c) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr_c;
          end
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          timeout_o = 1'b1;
          state_d   = S_IDLE;
          rr_ptr_d  = next_ptr_c;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any transaction in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      addr_q    <= '0;
      tmo_cnt_q <= '0;
      killed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      tmo_cnt_q <= tmo_cnt_d;
      killed_q  <= killed_d;
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: cycle vector table plus hand sequences,
// beat delivery checked through an expected-response queue.
module tb_mem_refill_arbiter;

  localparam int unsigned TB_TMO = 64;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [1:0]   req_valid_i;
  logic [51:0]  req_addr_i;
  logic [1:0]   req_ready_o;
  logic [1:0]   req_kill_i;
  logic         mem_acquire_valid_o;
  logic [25:0]  mem_acquire_addr_o;
  logic         mem_acquire_ready_i;
  logic         mem_grant_valid_i;
  logic [127:0] mem_grant_data_i;
  logic [1:0]   mem_grant_beat_i;
  logic         mem_grant_ready_o;
  logic [1:0]   resp_valid_o;
  logic [127:0] resp_data_o;
  logic [1:0]   resp_beat_o;
  logic         resp_last_o;
  logic         busy_o;
  logic         timeout_o;

  mem_refill_arbiter #(
    .N_REQ(2), .PADDR_W(26), .DATA_W(128), .BEAT_W(2), .TIMEOUT(TB_TMO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .req_kill_i(req_kill_i),
    .mem_acquire_valid_o(mem_acquire_valid_o), .mem_acquire_addr_o(mem_acquire_addr_o),
    .mem_acquire_ready_i(mem_acquire_ready_i),
    .mem_grant_valid_i(mem_grant_valid_i), .mem_grant_data_i(mem_grant_data_i),
    .mem_grant_beat_i(mem_grant_beat_i), .mem_grant_ready_o(mem_grant_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_beat_o(resp_beat_o),
    .resp_last_o(resp_last_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] rv;
    logic       ar;
    logic       gv;
    logic [1:0] gb;
    logic [1:0] kill;
    logic [1:0] e_ready;
    logic       e_acq;
    logic [1:0] e_resp;
    logic       e_last;
    logic       e_busy;
    logic       e_tmo;
  } vec_t;

  typedef struct {
    logic [1:0]   vld;
    logic [127:0] data;
    logic [1:0]   beat;
  } exp_t;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  vec_t         vecs[$];
  exp_t         sb[$];
  logic [25:0]  addr_tab [2];
  int           cur_owner = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rv, input logic ar, input logic gv,
                              input logic [1:0] gb, input logic [1:0] kill,
                              input logic [1:0] e_ready, input logic e_acq,
                              input logic [1:0] e_resp, input logic e_last,
                              input logic e_busy, input logic e_tmo);
    vec_t v;
    v.rv = rv; v.ar = ar; v.gv = gv; v.gb = gb; v.kill = kill;
    v.e_ready = e_ready; v.e_acq = e_acq; v.e_resp = e_resp;
    v.e_last = e_last; v.e_busy = e_busy; v.e_tmo = e_tmo;
    return v;
  endfunction

  // One clock cycle: drive at posedge+1, check combinational outputs at negedge.
  task automatic cyc(input vec_t v);
    exp_t e;
    req_valid_i         = v.rv;
    mem_acquire_ready_i = v.ar;
    mem_grant_valid_i   = v.gv;
    mem_grant_beat_i    = v.gb;
    req_kill_i          = v.kill;
    mem_grant_data_i    = {$urandom, $urandom, $urandom, $urandom};
    if (v.e_ready == 2'b01) cur_owner = 0;
    if (v.e_ready == 2'b10) cur_owner = 1;
    if (v.e_resp != 2'b00) begin
      e.vld  = v.e_resp;
      e.data = mem_grant_data_i;
      e.beat = v.gb;
      sb.push_back(e);
    end
    @(negedge clk_i);
    check("req_ready", 128'(req_ready_o), 128'(v.e_ready));
    check("acq_valid", 128'(mem_acquire_valid_o), 128'(v.e_acq));
    if (v.e_acq) check("acq_addr", 128'(mem_acquire_addr_o), 128'(addr_tab[cur_owner]));
    check("busy", 128'(busy_o), 128'(v.e_busy));
    check("timeout", 128'(timeout_o), 128'(v.e_tmo));
    check("resp_last", 128'(resp_last_o), 128'(v.e_last));
    check("grant_ready", 128'(mem_grant_ready_o), 128'(1'b1));
    if (!v.e_busy) begin
      check("resp_data_idle", resp_data_o, 128'(0));
      check("resp_beat_idle", 128'(resp_beat_o), 128'(0));
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_valid", 128'(resp_valid_o), 128'(e.vld));
      check("resp_data", resp_data_o, e.data);
      check("resp_beat", 128'(resp_beat_o), 128'(e.beat));
    end else begin
      check("resp_valid_none", 128'(resp_valid_o), 128'(0));
    end
    @(posedge clk_i);
    #1;
  endtask

  // Full burst with both clients requesting; beats returned out of index order.
  task automatic burst(input logic [1:0] oh);
    logic [1:0] order [4];
    order[0] = 2'd1; order[1] = 2'd0; order[2] = 2'd2; order[3] = 2'd3;
    cyc(mk(2'b11, 1'b0, 1'b0, 2'd0, 2'b00, oh,    1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    cyc(mk(2'b11, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0));
    cyc(mk(2'b11, 1'b1, 1'b0, 2'd0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0));
    for (int b = 0; b < 4; b++)
      cyc(mk(2'b11, 1'b0, 1'b1, order[b], 2'b00, 2'b00, 1'b0, oh,
             (order[b] == 2'd3), 1'b1, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_tab[0] = 26'h0123456;
    addr_tab[1] = 26'h2ABCDEF;
    req_addr_i  = {addr_tab[1], addr_tab[0]};
    rstn_i = 1'b0;
    req_valid_i = '0; req_kill_i = '0; mem_acquire_ready_i = 1'b0;
    mem_grant_valid_i = 1'b0; mem_grant_data_i = '0; mem_grant_beat_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_acq_valid", 128'(mem_acquire_valid_o), 128'(0));
    check("rst_req_ready", 128'(req_ready_o), 128'(0));
    check("rst_grant_ready", 128'(mem_grant_ready_o), 128'(1));
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Stray beat in IDLE, client 0 basic burst, client 1 killed burst, then rr check
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd3,2'b00, 2'b00,1'b0,2'b00,1'b0,1'b0,1'b0));
    vecs.push_back(mk(2'b01,1'b0,1'b0,2'd0,2'b00, 2'b01,1'b0,2'b00,1'b0,1'b0,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b1,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd0,2'b00, 2'b00,1'b0,2'b01,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd1,2'b00, 2'b00,1'b0,2'b01,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd2,2'b00, 2'b00,1'b0,2'b01,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd3,2'b00, 2'b00,1'b0,2'b01,1'b1,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b0,2'd0,2'b00, 2'b00,1'b0,2'b00,1'b0,1'b0,1'b0));
    vecs.push_back(mk(2'b10,1'b0,1'b0,2'd0,2'b00, 2'b10,1'b0,2'b00,1'b0,1'b0,1'b0));
    vecs.push_back(mk(2'b00,1'b1,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd0,2'b00, 2'b00,1'b0,2'b10,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd1,2'b00, 2'b00,1'b0,2'b10,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b0,2'd0,2'b10, 2'b00,1'b0,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd2,2'b00, 2'b00,1'b0,2'b00,1'b0,1'b1,1'b0));
    vecs.push_back(mk(2'b00,1'b0,1'b1,2'd3,2'b00, 2'b00,1'b0,2'b00,1'b1,1'b1,1'b0));
    vecs.push_back(mk(2'b11,1'b0,1'b0,2'd0,2'b00, 2'b01,1'b0,2'b00,1'b0,1'b0,1'b0));
    foreach (vecs[i]) cyc(vecs[i]);

    // Client 0 acquire completes, then no beats: timeout after TB_TMO silent cycles
    cyc(mk(2'b10,1'b1,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    for (int k = 1; k <= int'(TB_TMO); k++)
      cyc(mk(2'b10,1'b0,1'b0,2'd0,2'b00, 2'b00,1'b0,2'b00,1'b0,1'b1,(k == int'(TB_TMO))));

    // Client 1 served normally after the abort, reset lands on beat 2
    cyc(mk(2'b10,1'b0,1'b0,2'd0,2'b00, 2'b10,1'b0,2'b00,1'b0,1'b0,1'b0));
    cyc(mk(2'b00,1'b1,1'b0,2'd0,2'b00, 2'b00,1'b1,2'b00,1'b0,1'b1,1'b0));
    cyc(mk(2'b00,1'b0,1'b1,2'd0,2'b00, 2'b00,1'b0,2'b10,1'b0,1'b1,1'b0));
    cyc(mk(2'b00,1'b0,1'b1,2'd1,2'b00, 2'b00,1'b0,2'b10,1'b0,1'b1,1'b0));
    req_valid_i = 2'b00;
    mem_grant_valid_i = 1'b1;
    mem_grant_beat_i = 2'd2;
    mem_grant_data_i = 128'h5555_aaaa_1234_5678_9abc_def0_0f0f_f0f0;
    #1;
    check("pre_rst_resp_valid", 128'(resp_valid_o), 128'(2'b10));
    check("pre_rst_resp_data", resp_data_o, 128'h5555_aaaa_1234_5678_9abc_def0_0f0f_f0f0);
    rstn_i = 1'b0;
    #1;
    check("async_rst_resp_valid", 128'(resp_valid_o), 128'(0));
    check("async_rst_resp_data", resp_data_o, 128'(0));
    check("async_rst_resp_beat", 128'(resp_beat_o), 128'(0));
    check("async_rst_busy", 128'(busy_o), 128'(0));
    check("async_rst_acq_valid", 128'(mem_acquire_valid_o), 128'(0));
    check("async_rst_grant_ready", 128'(mem_grant_ready_o), 128'(1));
    mem_grant_valid_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Both clients request continuously: post-reset order 0,1,0,1
    burst(2'b01);
    burst(2'b10);
    burst(2'b01);
    burst(2'b10);
    cyc(mk(2'b00,1'b0,1'b0,2'd0,2'b00, 2'b00,1'b0,2'b00,1'b0,1'b0,1'b0));

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
